// File: rtl/bypass_scoreboard_pkg.sv
// Shared constants and the tracked-entry record for the operand-bypass scoreboard.
package bypass_scoreboard_pkg;
  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int NSTG_DEF = 3;
  localparam int LATW     = 4;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef struct packed {
    logic            v;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [LATW-1:0] lat;
  } entry_t;
endpackage

// File: rtl/bypass_scoreboard_if.sv
// Pipeline-control, issue and decode-read bundle between the core and the scoreboard.
interface bypass_scoreboard_if import bypass_scoreboard_pkg::*; #(
  parameter int NSTG = NSTG_DEF,
  parameter int NRD  = 2
);
  localparam int LW = (NSTG > 1) ? $clog2(NSTG) : 1;

  logic [NSTG-1:0]          adv;
  logic [NSTG-1:0]          flush;
  logic                     iss_valid;
  logic                     iss_we;
  logic [AW-1:0]            iss_waddr;
  logic [LW-1:0]            iss_lat;
  logic [NSTG-1:0][DW-1:0]  stg_data;
  logic [NRD-1:0]           rd_req;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][DW-1:0]   rf_rdata;
  logic [NRD-1:0][DW-1:0]   rd_data;
  logic                     rd_stall;
  logic [31:0]              stall_cnt;

  modport master (
    output adv, flush, iss_valid, iss_we, iss_waddr, iss_lat,
    output stg_data, rd_req, rd_addr, rf_rdata,
    input  rd_data, rd_stall, stall_cnt
  );

  modport slave (
    input  adv, flush, iss_valid, iss_we, iss_waddr, iss_lat,
    input  stg_data, rd_req, rd_addr, rf_rdata,
    output rd_data, rd_stall, stall_cnt
  );
endinterface

// File: rtl/bypass_scoreboard_fwd_match.sv
// One read port: find the youngest in-flight writer of the source register,
// forward its stage result if already produced, otherwise flag the port pending.
module fwd_match import bypass_scoreboard_pkg::*; #(
  parameter int NSTG = NSTG_DEF
) (
  input  entry_t [NSTG-1:0]         ents,
  input  logic   [NSTG-1:0][DW-1:0] stg_data,
  input  logic   [AW-1:0]           addr,
  input  logic   [DW-1:0]           rf_rdata,
  output logic   [DW-1:0]           data,
  output logic                      pending
);
  logic          hit;
  logic          ready;
  logic [DW-1:0] sel;

  // Scan oldest to youngest so the lowest matching stage is the last one kept.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    sel   = '0;
    for (int i = NSTG-1; i >= 0; i--) begin
      if (ents[i].v && ents[i].we && ents[i].waddr == addr && addr != '0) begin
        hit   = 1'b1;
        ready = (i >= int'(ents[i].lat));
        sel   = stg_data[i];
      end
    end
    data    = (hit && ready) ? sel : rf_rdata;
    pending = hit && !ready;
  end
endmodule

// File: rtl/bypass_scoreboard.sv
// Tracks destination tags from EX to WB and resolves decode operands:
// forward when the producer's result exists, stall when it does not yet.
module bypass_scoreboard import bypass_scoreboard_pkg::*; #(
  parameter int NSTG = NSTG_DEF,
  parameter int NRD  = 2
) (
  input logic               clk,
  input logic               reset,
  bypass_scoreboard_if.slave bus
);
  entry_t [NSTG-1:0] ent;
  entry_t [NSTG-1:0] src;
  logic   [NRD-1:0]  pend;
  logic   [31:0]     cnt_q;

  // Out-of-range latencies collapse onto the last tracked stage.
  function automatic logic [LATW-1:0] clamp_lat(input int lat);
    return (lat >= NSTG) ? LATW'(NSTG-1) : LATW'(lat);
  endfunction

  // A source flushed on this same edge must not be carried forward.
  always_comb begin
    src    = ent;
    src[0] = '{v: bus.iss_valid, we: bus.iss_we, waddr: bus.iss_waddr,
               lat: clamp_lat(int'(bus.iss_lat))};
    for (int i = 1; i < NSTG; i++) begin
      src[i]   = ent[i-1];
      src[i].v = ent[i-1].v & ~bus.flush[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent   <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NSTG; i++) begin
        if (bus.flush[i])    ent[i].v <= 1'b0;
        else if (bus.adv[i]) ent[i]   <= src[i];
      end
      if (bus.rd_stall && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_match #(.NSTG(NSTG)) u_fwd (
      .ents     (ent),
      .stg_data (bus.stg_data),
      .addr     (bus.rd_addr[p]),
      .rf_rdata (bus.rf_rdata[p]),
      .data     (bus.rd_data[p]),
      .pending  (pend[p])
    );
  end

  assign bus.rd_stall  = |(bus.rd_req & pend);
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed scenarios plus constrained-random traffic against a stage-occupancy model.
module tb_bypass_scoreboard;
  import bypass_scoreboard_pkg::*;
  localparam int NSTG = 3;
  localparam int NRD  = 2;
  localparam int LW   = $clog2(NSTG);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bypass_scoreboard_if #(.NSTG(NSTG), .NRD(NRD)) bif ();
  bypass_scoreboard #(.NSTG(NSTG), .NRD(NRD)) dut (.clk(clk), .reset(reset), .bus(bif));

  always #5 clk = ~clk;

  // Model: which instruction sits in each stage, and when its result appears.
  bit     m_v   [NSTG];
  bit     m_we  [NSTG];
  int     m_wa  [NSTG];
  int     m_lat [NSTG];
  longint m_cnt;

  function automatic void model_clear();
    for (int i = 0; i < NSTG; i++) begin
      m_v[i] = 0; m_we[i] = 0; m_wa[i] = 0; m_lat[i] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_eval(output logic [NRD-1:0][DW-1:0] d, output bit st);
    st = 0;
    for (int p = 0; p < NRD; p++) begin
      int hit = -1;
      d[p] = bif.rf_rdata[p];
      if (bif.rd_addr[p] != 0)
        for (int i = 0; i < NSTG; i++)
          if (hit < 0 && m_v[i] && m_we[i] && m_wa[i] == int'(bif.rd_addr[p])) hit = i;
      if (hit >= 0) begin
        if (hit >= m_lat[hit]) d[p] = bif.stg_data[hit];
        else if (bif.rd_req[p]) st = 1;
      end
    end
  endfunction

  task automatic tick();
    logic [NRD-1:0][DW-1:0] d;
    bit st;
    bit ov[NSTG]; bit owe[NSTG]; int owa[NSTG]; int olat[NSTG];
    @(posedge clk);
    for (int i = 0; i < NSTG-1; i++)
      if (!reset && bif.adv[i] && m_v[i+1] && !bif.adv[i+1])
        $error("illegal adv pattern %b", bif.adv);
    model_eval(d, st);
    if (reset) model_clear();
    else begin
      if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      ov = m_v; owe = m_we; owa = m_wa; olat = m_lat;
      for (int i = 0; i < NSTG; i++) begin
        if (bif.flush[i]) m_v[i] = 0;
        else if (bif.adv[i]) begin
          if (i == 0) begin
            m_v[0] = bif.iss_valid; m_we[0] = bif.iss_we; m_wa[0] = int'(bif.iss_waddr);
            m_lat[0] = (int'(bif.iss_lat) > NSTG-1) ? NSTG-1 : int'(bif.iss_lat);
          end else begin
            m_v[i] = ov[i-1] && !bif.flush[i-1]; m_we[i] = owe[i-1];
            m_wa[i] = owa[i-1]; m_lat[i] = olat[i-1];
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    bif.adv = '0; bif.flush = '0;
    bif.iss_valid = 0; bif.iss_we = 0; bif.iss_waddr = '0; bif.iss_lat = '0;
    bif.rd_req = '0; bif.rd_addr = '0;
    for (int i = 0; i < NSTG; i++) bif.stg_data[i] = DW'($urandom);
    for (int p = 0; p < NRD; p++) bif.rf_rdata[p] = DW'($urandom);
  endtask

  task automatic issue(input int wa, input int lat, input bit valid);
    bif.adv = '1; bif.iss_valid = valid; bif.iss_we = 1;
    bif.iss_waddr = AW'(wa); bif.iss_lat = LW'(lat);
    tick();
    bif.adv = '0; bif.iss_valid = 0;
  endtask

  task automatic test_reset();
    idle(); bif.rd_req = '1; bif.iss_valid = 1; bif.adv = '1;
    bif.rd_addr[0] = 5'd3; bif.rd_addr[1] = 5'd4;
    tick(); tick();
    reset = 0; idle(); bif.rd_req = '1; bif.rd_addr[0] = 5'd3;
    #1;
    n_vec++; if (bif.rd_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", bif.rd_stall); end
    n_vec++; if (bif.stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %h exp 0", bif.stall_cnt); end
    n_vec++; if (bif.rd_data !== bif.rf_rdata) begin n_err++; $display("FAIL reset_data got %h exp %h", bif.rd_data, bif.rf_rdata); end
  endtask

  task automatic test_back_to_back();
    idle(); issue(5, 0, 1);
    bif.stg_data[0] = 32'h11; bif.rd_req = 2'b01; bif.rd_addr[0] = 5'd5;
    #1;
    n_vec++; if (bif.rd_data[0] !== 32'h11) begin n_err++; $display("FAIL b2b_data got %h exp 11", bif.rd_data[0]); end
    n_vec++; if (bif.rd_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall got %b exp 0", bif.rd_stall); end
  endtask

  task automatic test_load_use();
    idle(); issue(6, 1, 1);
    bif.rd_req = 2'b01; bif.rd_addr[0] = 5'd6;
    #1;
    n_vec++; if (bif.rd_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", bif.rd_stall); end
    n_vec++; if (bif.stall_cnt !== 32'd0) begin n_err++; $display("FAIL lu_cnt0 got %h exp 0", bif.stall_cnt); end
    tick();
    n_vec++; if (bif.stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt1 got %h exp 1", bif.stall_cnt); end
    bif.adv = '1; tick(); bif.adv = '0;
    bif.stg_data[1] = 32'hCAFE;
    #1;
    n_vec++; if (bif.rd_data[0] !== 32'hCAFE) begin n_err++; $display("FAIL lu_fwd got %h exp cafe", bif.rd_data[0]); end
    n_vec++; if (bif.rd_stall !== 1'b0) begin n_err++; $display("FAIL lu_nostall got %b exp 0", bif.rd_stall); end
    n_vec++; if (bif.stall_cnt !== 32'd2) begin n_err++; $display("FAIL lu_cnt2 got %h exp 2", bif.stall_cnt); end
  endtask

  task automatic test_youngest();
    idle(); issue(7, 0, 1); issue(0, 0, 1); issue(7, 0, 1);
    bif.stg_data[2] = 32'hA; bif.stg_data[0] = 32'hB; bif.rf_rdata[1] = 32'h1234;
    bif.rd_req = 2'b11; bif.rd_addr[0] = 5'd7; bif.rd_addr[1] = 5'd0;
    #1;
    n_vec++; if (bif.rd_data[0] !== 32'hB) begin n_err++; $display("FAIL young_data got %h exp b", bif.rd_data[0]); end
    n_vec++; if (bif.rd_data[1] !== 32'h1234) begin n_err++; $display("FAIL r0_data got %h exp 1234", bif.rd_data[1]); end
    n_vec++; if (bif.rd_stall !== 1'b0) begin n_err++; $display("FAIL young_stall got %b exp 0", bif.rd_stall); end
  endtask

  task automatic test_flush();
    idle(); issue(8, 1, 1);
    bif.flush = 3'b001; tick(); bif.flush = '0;
    bif.rd_req = 2'b01; bif.rd_addr[0] = 5'd8; bif.rf_rdata[0] = 32'h5555_0008;
    #1;
    n_vec++; if (bif.rd_data[0] !== 32'h5555_0008) begin n_err++; $display("FAIL flush_data got %h exp 55550008", bif.rd_data[0]); end
    n_vec++; if (bif.rd_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b exp 0", bif.rd_stall); end
  endtask

  task automatic test_hold_and_async_reset();
    idle(); issue(10, 0, 1); issue(0, 0, 0); issue(9, 0, 1);
    bif.adv = 3'b100; tick(); tick(); tick(); bif.adv = '0;
    bif.stg_data[0] = 32'h99; bif.stg_data[2] = 32'h77; bif.rf_rdata[1] = 32'hBEEF;
    bif.rd_req = 2'b11; bif.rd_addr[0] = 5'd9; bif.rd_addr[1] = 5'd10;
    #1;
    n_vec++; if (bif.rd_data[0] !== 32'h99) begin n_err++; $display("FAIL hold_s0 got %h exp 99", bif.rd_data[0]); end
    n_vec++; if (bif.rd_data[1] !== 32'hBEEF) begin n_err++; $display("FAIL hold_s2 got %h exp beef", bif.rd_data[1]); end
    idle(); issue(11, 2, 1);
    bif.rd_req = 2'b01; bif.rd_addr[0] = 5'd11;
    #1;
    n_vec++; if (bif.rd_stall !== 1'b1) begin n_err++; $display("FAIL ar_pre got %b exp 1", bif.rd_stall); end
    #1 reset = 1; #1 reset = 0; model_clear();
    #1;
    n_vec++; if (bif.rd_stall !== 1'b0) begin n_err++; $display("FAIL ar_stall got %b exp 0", bif.rd_stall); end
    n_vec++; if (bif.stall_cnt !== 32'd0) begin n_err++; $display("FAIL ar_cnt got %h exp 0", bif.stall_cnt); end
    n_vec++; if (bif.rd_data[0] !== bif.rf_rdata[0]) begin n_err++; $display("FAIL ar_data got %h exp %h", bif.rd_data[0], bif.rf_rdata[0]); end
  endtask

  task automatic test_saturation();
    idle(); issue(12, 3, 1);
    bif.rd_req = 2'b01; bif.rd_addr[0] = 5'd12;
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    m_cnt = 64'hFFFF_FFFE;
    #1;
    n_vec++; if (bif.stall_cnt !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_pre got %h exp fffffffe", bif.stall_cnt); end
    tick();
    n_vec++; if (bif.stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_1 got %h exp ffffffff", bif.stall_cnt); end
    tick(); tick();
    n_vec++; if (bif.stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_3 got %h exp ffffffff", bif.stall_cnt); end
    bif.adv = '1; tick();
    n_vec++; if (bif.rd_stall !== 1'b1) begin n_err++; $display("FAIL clamp_s1 got %b exp 1", bif.rd_stall); end
    tick(); bif.adv = '0;
    bif.stg_data[2] = 32'h2222;
    #1;
    n_vec++; if (bif.rd_data[0] !== 32'h2222) begin n_err++; $display("FAIL clamp_s2 got %h exp 2222", bif.rd_data[0]); end
    n_vec++; if (bif.rd_stall !== 1'b0) begin n_err++; $display("FAIL clamp_nostall got %b exp 0", bif.rd_stall); end
  endtask

  task automatic test_random();
    logic [NRD-1:0][DW-1:0] d;
    bit st;
    logic [NSTG-1:0] a;
    for (int n = 0; n < 400; n++) begin
      a = NSTG'($urandom);
      for (int i = NSTG-2; i >= 0; i--)
        if (a[i] && m_v[i+1] && !a[i+1]) a[i] = 1'b0;
      bif.adv = a;
      bif.flush = ($urandom_range(7) == 0) ? NSTG'($urandom) : '0;
      bif.iss_valid = 1'($urandom); bif.iss_we = 1'($urandom);
      bif.iss_waddr = AW'($urandom_range(7)); bif.iss_lat = LW'($urandom_range(3));
      bif.rd_req = NRD'($urandom);
      for (int p = 0; p < NRD; p++) begin
        bif.rd_addr[p] = AW'($urandom_range(7)); bif.rf_rdata[p] = DW'($urandom);
      end
      for (int i = 0; i < NSTG; i++) bif.stg_data[i] = DW'($urandom);
      #1;
      model_eval(d, st);
      for (int p = 0; p < NRD; p++) begin
        n_vec++;
        if (bif.rd_data[p] !== d[p]) begin
          n_err++; $display("FAIL rnd_data[%0d] cyc %0d got %h exp %h", p, n, bif.rd_data[p], d[p]);
        end
      end
      n_vec++; if (bif.rd_stall !== st) begin n_err++; $display("FAIL rnd_stall cyc %0d got %b exp %b", n, bif.rd_stall, st); end
      n_vec++; if (bif.stall_cnt !== m_cnt[31:0]) begin n_err++; $display("FAIL rnd_cnt cyc %0d got %h exp %h", n, bif.stall_cnt, m_cnt[31:0]); end
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_flush();
    test_hold_and_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
